gp_timer: RTL and testbench

General-purpose timer: the multi-channel successor of the basic prescaled auto-reload timer. It adds up/down counting, shadowed period, direction and compare registers, and 1–4 compare/PWM channels with per-channel match interrupts. Optional per-channel input capture is available at compile time. It sits behind the APB timer register block, which drives all configuration inputs and collects the interrupt pulses.

---
 rtl/gp_timer.sv | 162 ++++++++++++++++
 tb/tb_gp_timer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gp_timer.sv
// Multi-channel prescaled up/down timer with shadowed period/direction/compare and PWM outputs.
// Define GP_TIMER_CAPTURE_EN to build the per-channel input-capture logic.
module gp_timer #(
    parameter int timer_width      = 16,
    parameter int chn_n            = 2,
    parameter int simulation_delay = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [timer_width-1:0]       prescale,
    input  logic [timer_width-1:0]       autoload,
    input  logic                         count_dir,
    input  logic                         timer_started,
    input  logic                         timer_cnt_to_set,
    input  logic [timer_width-1:0]       timer_cnt_set_v,
    output logic [timer_width-1:0]       timer_cnt_now_v,
    input  logic [chn_n*timer_width-1:0] cmp_v,
    input  logic [chn_n-1:0]             chn_mode,
    input  logic [chn_n-1:0]             cap_in,
    input  logic [chn_n*2-1:0]           cap_edge,
    output logic [chn_n*timer_width-1:0] cap_v,
    output logic [chn_n-1:0]             pwm_out,
    output logic                         timer_expired,
    output logic                         timer_expired_itr_req,
    output logic [chn_n-1:0]             chn_itr_req
);

    // The RTL carries no assignment delays; the parameter only keeps the interface compatible.
    localparam int unusedSimDelay = simulation_delay;
    localparam logic [timer_width-1:0] One = {{(timer_width-1){1'b0}}, 1'b1};

    logic [timer_width-1:0] prescaleCnt_q, prescaleCnt_d;
    logic [timer_width-1:0] prescaleShadow_q, prescaleShadow_d;
    logic [timer_width-1:0] autoloadShadow_q, autoloadShadow_d;
    logic                   dirShadow_q, dirShadow_d;
    logic [timer_width-1:0] cnt_q, cnt_d;
    logic [timer_width-1:0] cmpShadow_q [chn_n];
    logic [timer_width-1:0] cmpShadow_d [chn_n];
    logic                   expItr_q, expItr_d;
    logic [chn_n-1:0]       pwm_q, pwm_d;
    logic [chn_n-1:0]       chnItr_q, chnItr_d;
    logic [chn_n-1:0]       chnMode;
    logic [chn_n-1:0]       capHitNow;
    logic                   tick, atWrap, updateEvt, shadowLoad;

`ifdef GP_TIMER_CAPTURE_EN
    logic [chn_n-1:0]       sync0_q, sync1_q, sync2_q;
    logic [chn_n-1:0]       capHit_q, capHit_d;
    logic [timer_width-1:0] capVal_q [chn_n];
    logic                   rise, fall;

    assign chnMode = chn_mode;

    // sync0/sync1 resynchronise cap_in; sync2 is the history stage the edge detector compares against.
    always_comb begin
        capHit_d = '0;
        rise     = 1'b0;
        fall     = 1'b0;
        for (int i = 0; i < chn_n; i++) begin
            rise = sync1_q[i] & ~sync2_q[i];
            fall = ~sync1_q[i] & sync2_q[i];
            if (cap_edge[2*i+1])
                capHit_d[i] = timer_started & chn_mode[i] & (rise | fall);
            else if (cap_edge[2*i])
                capHit_d[i] = timer_started & chn_mode[i] & fall;
            else
                capHit_d[i] = timer_started & chn_mode[i] & rise;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0_q  <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            capHit_q <= '0;
            for (int i = 0; i < chn_n; i++) capVal_q[i] <= '0;
        end else begin
            sync0_q  <= cap_in;
            sync1_q  <= sync0_q;
            sync2_q  <= sync1_q;
            capHit_q <= capHit_d;
            for (int i = 0; i < chn_n; i++)
                if (capHit_q[i] && timer_started) capVal_q[i] <= cnt_q;
        end
    end

    assign capHitNow = capHit_q & {chn_n{timer_started}};

    always_comb begin
        cap_v = '0;
        for (int i = 0; i < chn_n; i++) cap_v[i*timer_width +: timer_width] = capVal_q[i];
    end
`else
    logic unusedCapIns;

    assign unusedCapIns = ^{chn_mode, cap_in, cap_edge};
    assign chnMode      = '0;
    assign capHitNow    = '0;
    assign cap_v        = '0;
`endif

    // A counter load overrides the tick, so it also masks the update event and any match.
    always_comb begin
        tick             = timer_started && (prescaleCnt_q == prescaleShadow_q);
        atWrap           = dirShadow_q ? (cnt_q == '0) : (cnt_q == autoloadShadow_q);
        updateEvt        = tick && !timer_cnt_to_set && atWrap;
        shadowLoad       = !timer_started || updateEvt;
        prescaleCnt_d    = (!timer_started || tick) ? '0 : prescaleCnt_q + One;
        prescaleShadow_d = (!timer_started || (prescaleCnt_q == prescaleShadow_q)) ? prescale
                                                                                     : prescaleShadow_q;
        autoloadShadow_d = shadowLoad ? autoload : autoloadShadow_q;
        dirShadow_d      = shadowLoad ? count_dir : dirShadow_q;
        expItr_d         = updateEvt;
        cnt_d            = cnt_q;
        if (timer_cnt_to_set)
            cnt_d = timer_cnt_set_v;
        else if (tick && atWrap)
            cnt_d = dirShadow_q ? autoloadShadow_q : '0;
        else if (tick)
            cnt_d = dirShadow_q ? cnt_q - One : cnt_q + One;
        pwm_d    = '0;
        chnItr_d = '0;
        for (int i = 0; i < chn_n; i++) begin
            cmpShadow_d[i] = shadowLoad ? cmp_v[i*timer_width +: timer_width] : cmpShadow_q[i];
            pwm_d[i]       = timer_started && !chnMode[i] && (cnt_q < cmpShadow_q[i]);
            chnItr_d[i]    = chnMode[i] ? capHitNow[i]
                                        : (tick && !timer_cnt_to_set && (cnt_q == cmpShadow_q[i]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaleCnt_q    <= '0;
            prescaleShadow_q <= '0;
            autoloadShadow_q <= '0;
            dirShadow_q      <= 1'b0;
            cnt_q            <= '0;
            expItr_q         <= 1'b0;
            pwm_q            <= '0;
            chnItr_q         <= '0;
            for (int i = 0; i < chn_n; i++) cmpShadow_q[i] <= '0;
        end else begin
            prescaleCnt_q    <= prescaleCnt_d;
            prescaleShadow_q <= prescaleShadow_d;
            autoloadShadow_q <= autoloadShadow_d;
            dirShadow_q      <= dirShadow_d;
            cnt_q            <= cnt_d;
            expItr_q         <= expItr_d;
            pwm_q            <= pwm_d;
            chnItr_q         <= chnItr_d;
            for (int i = 0; i < chn_n; i++) cmpShadow_q[i] <= cmpShadow_d[i];
        end
    end

    assign timer_cnt_now_v       = cnt_q;
    assign timer_expired         = updateEvt;
    assign timer_expired_itr_req = expItr_q;
    assign pwm_out               = pwm_q;
    assign chn_itr_req           = chnItr_q;

endmodule

// File: tb/tb_gp_timer.sv
// Directed self-checking bench for gp_timer (timer_width=16, chn_n=2).
module tb_gp_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] prescale, autoload, timer_cnt_set_v, timer_cnt_now_v;
    logic        count_dir, timer_started, timer_cnt_to_set;
    logic [31:0] cmp_v, cap_v;
    logic [1:0]  chn_mode, cap_in, pwm_out, chn_itr_req;
    logic [3:0]  cap_edge;
    logic        timer_expired, timer_expired_itr_req;

    int checks   = 0;
    int failures = 0;
    int pwm0Hi, pwm1Hi, itr0N, itr1N, expN;

`ifdef GP_TIMER_CAPTURE_EN
    localparam bit CapOn = 1'b1;
`else
    localparam bit CapOn = 1'b0;
`endif

    gp_timer #(.timer_width(16), .chn_n(2), .simulation_delay(1)) dut (
        .clk(clk), .rst(rst), .prescale(prescale), .autoload(autoload),
        .count_dir(count_dir), .timer_started(timer_started),
        .timer_cnt_to_set(timer_cnt_to_set), .timer_cnt_set_v(timer_cnt_set_v),
        .timer_cnt_now_v(timer_cnt_now_v), .cmp_v(cmp_v), .chn_mode(chn_mode),
        .cap_in(cap_in), .cap_edge(cap_edge), .cap_v(cap_v), .pwm_out(pwm_out),
        .timer_expired(timer_expired), .timer_expired_itr_req(timer_expired_itr_req),
        .chn_itr_req(chn_itr_req)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] pre, input logic [15:0] arl, input logic dir,
                                 input logic start, input logic setEn, input logic [15:0] setVal);
        prescale         = pre;
        autoload         = arl;
        count_dir        = dir;
        timer_started    = start;
        timer_cnt_to_set = setEn;
        timer_cnt_set_v  = setVal;
    endtask

    task automatic stepClocks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        cmp_v = 32'd0; chn_mode = 2'b00; cap_in = 2'b00; cap_edge = 4'b0000;
        #2;
        checkOutput("rst_cnt", 32'(timer_cnt_now_v), 32'd0);
        checkOutput("rst_pwm", 32'(pwm_out), 32'd0);
        checkOutput("rst_exp", 32'(timer_expired), 32'd0);
        checkOutput("rst_expitr", 32'(timer_expired_itr_req), 32'd0);
        checkOutput("rst_chnitr", 32'(chn_itr_req), 32'd0);
        checkOutput("rst_capv", cap_v, 32'd0);
        stepClocks(2);
        rst = 1'b0;

        // Up count, prescale 3, period 5 ticks = 15 clocks.
        applyStimulus(16'd2, 16'd4, 1'b0, 1'b0, 1'b0, 16'd0);
        stepClocks(2);
        timer_started = 1'b1;
        stepClocks(2);
        checkOutput("up_cnt_e2", 32'(timer_cnt_now_v), 32'd0);
        stepClocks(1);
        checkOutput("up_cnt_e3", 32'(timer_cnt_now_v), 32'd1);
        stepClocks(9);
        checkOutput("up_cnt_e12", 32'(timer_cnt_now_v), 32'd4);
        checkOutput("up_exp_early", 32'(timer_expired), 32'd0);
        stepClocks(2);
        checkOutput("up_exp_e14", 32'(timer_expired), 32'd1);
        checkOutput("up_itr_e14", 32'(timer_expired_itr_req), 32'd0);
        stepClocks(1);
        checkOutput("up_cnt_e15", 32'(timer_cnt_now_v), 32'd0);
        checkOutput("up_exp_e15", 32'(timer_expired), 32'd0);
        checkOutput("up_itr_e15", 32'(timer_expired_itr_req), 32'd1);
        stepClocks(1);
        checkOutput("up_itr_e16", 32'(timer_expired_itr_req), 32'd0);
        stepClocks(13);
        checkOutput("up_exp_e29", 32'(timer_expired), 32'd1);
        stepClocks(1);
        checkOutput("up_itr_e30", 32'(timer_expired_itr_req), 32'd1);

        // Asynchronous reset drops the pending pulse immediately.
        rst = 1'b1;
        #1;
        checkOutput("arst_itr", 32'(timer_expired_itr_req), 32'd0);
        checkOutput("arst_cnt", 32'(timer_cnt_now_v), 32'd0);
        stepClocks(1);
        rst = 1'b0;

        // Down count from 3, prescale 1.
        applyStimulus(16'd0, 16'd3, 1'b1, 1'b0, 1'b1, 16'd3);
        stepClocks(1);
        checkOutput("dn_load", 32'(timer_cnt_now_v), 32'd3);
        timer_started = 1'b1; timer_cnt_to_set = 1'b0;
        stepClocks(1);
        checkOutput("dn_cnt2", 32'(timer_cnt_now_v), 32'd2);
        stepClocks(1);
        checkOutput("dn_cnt1", 32'(timer_cnt_now_v), 32'd1);
        stepClocks(1);
        checkOutput("dn_cnt0", 32'(timer_cnt_now_v), 32'd0);
        checkOutput("dn_exp0", 32'(timer_expired), 32'd1);
        stepClocks(1);
        checkOutput("dn_wrap", 32'(timer_cnt_now_v), 32'd3);
        checkOutput("dn_itr", 32'(timer_expired_itr_req), 32'd1);
        stepClocks(3);
        checkOutput("dn_exp_next", 32'(timer_expired), 32'd1);

        // PWM: autoload 9, cmp0=3, cmp1=12.
        applyStimulus(16'd0, 16'd9, 1'b0, 1'b0, 1'b1, 16'd0);
        cmp_v = {16'd12, 16'd3};
        stepClocks(1);
        timer_started = 1'b1; timer_cnt_to_set = 1'b0;
        pwm0Hi = 0; pwm1Hi = 0; itr0N = 0; itr1N = 0; expN = 0;
        for (int n = 1; n <= 20; n++) begin
            stepClocks(1);
            pwm0Hi += int'(pwm_out[0]);
            pwm1Hi += int'(pwm_out[1]);
            itr0N  += int'(chn_itr_req[0]);
            itr1N  += int'(chn_itr_req[1]);
            expN   += int'(timer_expired_itr_req);
        end
        checkOutput("pwm0_high", 32'(pwm0Hi), 32'd6);
        checkOutput("pwm1_high", 32'(pwm1Hi), 32'd20);
        checkOutput("itr0_cnt", 32'(itr0N), 32'd2);
        checkOutput("itr1_cnt", 32'(itr1N), 32'd0);
        checkOutput("exp_cnt", 32'(expN), 32'd2);

        // Mid-period rewrite of autoload and cmp0 applies after the current period.
        stepClocks(2);
        autoload = 16'd4; cmp_v = {16'd12, 16'd1};
        stepClocks(3);
        checkOutput("mid_old_period", 32'(timer_cnt_now_v), 32'd5);
        stepClocks(4);
        checkOutput("mid_exp9", 32'(timer_expired), 32'd1);
        checkOutput("mid_cnt9", 32'(timer_cnt_now_v), 32'd9);
        stepClocks(1);
        checkOutput("mid_wrap", 32'(timer_cnt_now_v), 32'd0);
        stepClocks(1);
        checkOutput("mid_pwm0_hi", 32'(pwm_out[0]), 32'd1);
        stepClocks(1);
        checkOutput("mid_pwm0_lo", 32'(pwm_out[0]), 32'd0);
        checkOutput("mid_match", 32'(chn_itr_req[0]), 32'd1);
        stepClocks(2);
        checkOutput("mid_exp4", 32'(timer_expired), 32'd1);
        checkOutput("mid_cnt4", 32'(timer_cnt_now_v), 32'd4);

        // Counter load on a tick masks match and update.
        stepClocks(2);
        timer_cnt_to_set = 1'b1; timer_cnt_set_v = 16'd4;
        stepClocks(1);
        checkOutput("set_cnt4", 32'(timer_cnt_now_v), 32'd4);
        checkOutput("set_nomatch", 32'(chn_itr_req[0]), 32'd0);
        timer_cnt_set_v = 16'd7;
        #1;
        checkOutput("set_noexp", 32'(timer_expired), 32'd0);
        stepClocks(1);
        checkOutput("set_cnt7", 32'(timer_cnt_now_v), 32'd7);
        checkOutput("set_noitr", 32'(timer_expired_itr_req), 32'd0);
        timer_cnt_set_v = 16'hFFFE;
        stepClocks(1);
        timer_cnt_to_set = 1'b0;
        checkOutput("ovf_cnt", 32'(timer_cnt_now_v), 32'h0000FFFE);
        checkOutput("ovf_noexp_a", 32'(timer_expired), 32'd0);
        stepClocks(1);
        checkOutput("ovf_cnt_max", 32'(timer_cnt_now_v), 32'h0000FFFF);
        checkOutput("ovf_noexp_b", 32'(timer_expired), 32'd0);
        stepClocks(1);
        checkOutput("ovf_wrap0", 32'(timer_cnt_now_v), 32'd0);
        checkOutput("ovf_noitr", 32'(timer_expired_itr_req), 32'd0);
        stepClocks(1);
        checkOutput("stop_pre_pwm1", 32'(pwm_out[1]), 32'd1);

        // Stop: counter holds, PWM falls one cycle later.
        timer_started = 1'b0;
        stepClocks(1);
        checkOutput("stop_hold", 32'(timer_cnt_now_v), 32'd1);
        checkOutput("stop_pwm", 32'(pwm_out), 32'd0);

        // Channel 0 in capture mode, rising edge.
        applyStimulus(16'd0, 16'd9, 1'b0, 1'b0, 1'b1, 16'd0);
        chn_mode = 2'b01; cap_edge = 4'b0000;
        stepClocks(1);
        timer_started = 1'b1; timer_cnt_to_set = 1'b0;
        stepClocks(1);
        checkOutput("cap_pwm0", 32'(pwm_out[0]), CapOn ? 32'd0 : 32'd1);
        stepClocks(4);
        checkOutput("cap_cnt5", 32'(timer_cnt_now_v), 32'd5);
        cap_in = 2'b01;
        stepClocks(3);
        checkOutput("cap_early_v", cap_v, 32'd0);
        checkOutput("cap_early_itr", 32'(chn_itr_req[0]), 32'd0);
        stepClocks(1);
        checkOutput("cap_v0", cap_v, CapOn ? 32'd8 : 32'd0);
        checkOutput("cap_itr", 32'(chn_itr_req[0]), CapOn ? 32'd1 : 32'd0);
        stepClocks(1);
        checkOutput("cap_itr_end", 32'(chn_itr_req[0]), 32'd0);
        cap_in = 2'b00;
        itr0N = 0;
        for (int n = 0; n < 5; n++) begin
            stepClocks(1);
            itr0N += int'(chn_itr_req[0]);
        end
        checkOutput("cap_fall_itr", 32'(itr0N), CapOn ? 32'd0 : 32'd1);
        checkOutput("cap_fall_v", cap_v, CapOn ? 32'd8 : 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
